// File: rtl/round_controller.sv
// round_controller -- sequencing core of a colour-logic reaction game.
//
// A free-running 16-bit LFSR provides the random round. Each round latches
// four 2-bit selectors, asks the display stage to draw them, waits for the
// frame to finish, then opens a response window for a single keypress. The
// key is judged against the round's logic rule. A correct key bumps the
// score and starts the next round. A wrong key ends the game.
//
// Ports
//   clock                 sole clock, rising edge
//   resetn                asynchronous active-low reset
//   start                 one-cycle request to begin a game (idle/over only)
//   key_valid, key_code   one-cycle keypress strobe and colour (0 R,1 G,2 B,3 Y)
//   done_draw             display level; a rising edge marks frame complete
//   draw_enable           one-cycle draw request for the current round
//   not_not_selector, color_logic_selector,
//   color_selector_1, color_selector_2   round selectors (bit 2 always 0)
//   score                 correct rounds this game, saturating at 255
//   round_active          response window open
//   game_over             game ended; selectors and score held
//   result_valid/correct  one-cycle verdict strobe and verdict
//
// Configuration macro ROUND_TIMEOUT_EN: bounds the response window to
// TIMEOUT_CYCLES. An unanswered window is judged as "no key". Without the
// macro the window is unbounded, and an unanswerable AND round is rewritten
// at generation time so that a correct key always exists.
module round_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       key_valid,
    input  logic [1:0] key_code,
    input  logic       done_draw,
    output logic       draw_enable,
    output logic [2:0] not_not_selector,
    output logic [2:0] color_logic_selector,
    output logic [2:0] color_selector_1,
    output logic [2:0] color_selector_2,
    output logic [7:0] score,
    output logic       round_active,
    output logic       game_over,
    output logic       result_valid,
    output logic       result_correct
);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_DRAW, S_WAIT_DRAW, S_RESPOND, S_CHECK, S_OVER
    } state_t;

    // An all-zero seed would lock the LFSR. Fall back to a non-zero value.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    state_t      state, state_next;
    logic [15:0] lfsr;
    logic        done_prev;
    logic        done_rise;
    logic [1:0]  sel_not, sel_logic, sel_c1, sel_c2;
    logic [1:0]  key_q;
    logic [1:0]  gen_c2;
    logic [1:0]  c2n;
    logic [3:0]  target;
    logic        key_hit;
    logic        verdict;

`ifdef ROUND_TIMEOUT_EN
    logic [31:0] timer;
    logic        no_key;
    logic        timeout_hit;
    assign timeout_hit = (timer == 32'(TIMEOUT_CYCLES - 1));
`endif

    assign done_rise = done_draw & ~done_prev;

    assign not_not_selector     = {1'b0, sel_not};
    assign color_logic_selector = {1'b0, sel_logic};
    assign color_selector_1     = {1'b0, sel_c1};
    assign color_selector_2     = {1'b0, sel_c2};

    // color_selector_2 is stored in reversed colour order (3 red .. 0 yellow).
    // c2n brings it back to key_code order. T is held as a one-hot-per-colour mask.
    always_comb begin
        gen_c2 = lfsr[7:6];
`ifndef ROUND_TIMEOUT_EN
        if (lfsr[3:2] == 2'd2 && lfsr[5:4] != 2'd3 - lfsr[7:6])
            gen_c2 = 2'd3 - lfsr[5:4];
`endif
        c2n    = 2'd3 - sel_c2;
        target = 4'b0001 << sel_c1;
        case (sel_logic)
            2'd1:    target = target | (4'b0001 << c2n);
            2'd2:    if (sel_c1 != c2n) target = 4'b0000;
            default: ;
        endcase
        key_hit = target[key_q];
`ifdef ROUND_TIMEOUT_EN
        // With no key, the verdict is correct only when no colour could have
        // been right. That requires an even "not" and an empty target set.
        verdict = no_key ? (~sel_not[0] & (target == 4'b0000))
                         : (sel_not[0] ? ~key_hit : key_hit);
`else
        verdict = sel_not[0] ? ~key_hit : key_hit;
`endif
    end

    always_comb begin
        state_next     = state;
        draw_enable    = 1'b0;
        round_active   = 1'b0;
        game_over      = 1'b0;
        result_valid   = 1'b0;
        result_correct = 1'b0;
        case (state)
            S_IDLE:      if (start) state_next = S_GEN;
            S_GEN:       state_next = S_DRAW;
            S_DRAW: begin
                draw_enable = 1'b1;
                state_next  = S_WAIT_DRAW;
            end
            S_WAIT_DRAW: if (done_rise) state_next = S_RESPOND;
            S_RESPOND: begin
                round_active = 1'b1;
                if (key_valid) state_next = S_CHECK;
`ifdef ROUND_TIMEOUT_EN
                else if (timeout_hit) state_next = S_CHECK;
`endif
            end
            S_CHECK: begin
                result_valid   = 1'b1;
                result_correct = verdict;
                state_next     = verdict ? S_GEN : S_OVER;
            end
            S_OVER: begin
                game_over = 1'b1;
                if (start) state_next = S_GEN;
            end
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            lfsr      <= SEED;
            done_prev <= 1'b0;
            sel_not   <= 2'd0;
            sel_logic <= 2'd0;
            sel_c1    <= 2'd0;
            sel_c2    <= 2'd0;
            key_q     <= 2'd0;
            score     <= 8'd0;
`ifdef ROUND_TIMEOUT_EN
            timer     <= 32'd0;
            no_key    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            // Fibonacci LFSR, taps 16,14,13,11
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            done_prev <= done_draw;
            if ((state == S_IDLE || state == S_OVER) && start)
                score <= 8'd0;
            if (state == S_GEN) begin
                sel_not   <= lfsr[1:0];
                sel_logic <= lfsr[3:2];
                sel_c1    <= lfsr[5:4];
                sel_c2    <= gen_c2;
            end
            if (state == S_RESPOND && key_valid)
                key_q <= key_code;
            if (state == S_CHECK && verdict && score != 8'hFF)
                score <= score + 8'd1;
`ifdef ROUND_TIMEOUT_EN
            if (state == S_WAIT_DRAW)
                timer <= 32'd0;
            else if (state == S_RESPOND)
                timer <= timer + 32'd1;
            if (state == S_RESPOND)
                no_key <= ~key_valid;
`endif
        end
    end

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

    localparam int TO = 16;
    localparam int P_IDLE = 0, P_GEN = 1, P_DRAW = 2, P_WAIT = 3,
                   P_RESP = 4, P_CHECK = 5, P_OVER = 6;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_code = 2'd0;
    logic       done_draw = 1'b0;
    logic       draw_enable, round_active, game_over, result_valid, result_correct;
    logic [2:0] not_sel, logic_sel, c1_sel, c2_sel;
    logic [7:0] score;

    round_controller #(.TIMEOUT_CYCLES(TO), .LFSR_SEED(16'hACE1)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .key_valid(key_valid), .key_code(key_code), .done_draw(done_draw),
        .draw_enable(draw_enable),
        .not_not_selector(not_sel), .color_logic_selector(logic_sel),
        .color_selector_1(c1_sel), .color_selector_2(c2_sel),
        .score(score), .round_active(round_active), .game_over(game_over),
        .result_valid(result_valid), .result_correct(result_correct)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit [15:0] lfsr_next(input bit [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Colour set the round asks for, as a set of key_code values.
    function automatic bit [3:0] target_set(input bit [1:0] lg, input bit [1:0] c1, input bit [1:0] c2);
        int c2n;
        bit [3:0] t;
        c2n = 3 - int'(c2);
        t = '0;
        if (lg == 1) begin
            t[c1] = 1'b1;
            t[c2n] = 1'b1;
        end else if (lg == 2) begin
            if (int'(c1) == c2n) t[c1] = 1'b1;
        end else begin
            t[c1] = 1'b1;
        end
        return t;
    endfunction

    function automatic bit key_correct(input bit [1:0] nt, input bit [1:0] lg,
                                       input bit [1:0] c1, input bit [1:0] c2, input int k);
        bit [3:0] t;
        t = target_set(lg, c1, c2);
        return (nt % 2 == 0) ? t[k] : !t[k];
    endfunction

    function automatic bit any_correct(input bit [1:0] nt, input bit [1:0] lg,
                                       input bit [1:0] c1, input bit [1:0] c2);
        for (int k = 0; k < 4; k++)
            if (key_correct(nt, lg, c1, c2, k)) return 1'b1;
        return 1'b0;
    endfunction

    int       m_phase = P_IDLE;
    bit [15:0] m_lfsr;
    bit [1:0] m_not, m_lg, m_c1, m_c2;
    int       m_key;
    bit       m_nokey;
    int       m_score;
    bit       m_dprev;
    int       m_timer;

    function automatic bit m_verdict();
        if (m_nokey) return !any_correct(m_not, m_lg, m_c1, m_c2);
        return key_correct(m_not, m_lg, m_c1, m_c2, m_key);
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_phase = P_IDLE; m_lfsr = 16'hACE1;
            m_not = 0; m_lg = 0; m_c1 = 0; m_c2 = 0;
            m_key = 0; m_nokey = 0; m_score = 0; m_dprev = 0; m_timer = 0;
        end else begin
            case (m_phase)
                P_IDLE, P_OVER: if (start) begin m_phase = P_GEN; m_score = 0; end
                P_GEN: begin
                    m_not = m_lfsr[1:0]; m_lg = m_lfsr[3:2];
                    m_c1 = m_lfsr[5:4]; m_c2 = m_lfsr[7:6];
`ifndef ROUND_TIMEOUT_EN
                    if (target_set(m_lg, m_c1, m_c2) == 0) m_c2 = 2'(3 - int'(m_c1));
`endif
                    m_phase = P_DRAW;
                end
                P_DRAW: m_phase = P_WAIT;
                P_WAIT: if (done_draw && !m_dprev) begin m_phase = P_RESP; m_timer = 0; end
                P_RESP: begin
                    if (key_valid) begin
                        m_key = key_code; m_nokey = 0; m_phase = P_CHECK;
                    end
`ifdef ROUND_TIMEOUT_EN
                    else if (m_timer == TO - 1) begin
                        m_nokey = 1; m_phase = P_CHECK;
                    end else m_timer++;
`endif
                end
                P_CHECK: begin
                    if (m_verdict()) begin
                        if (m_score < 255) m_score++;
                        m_phase = P_GEN;
                    end else m_phase = P_OVER;
                end
                default: m_phase = P_IDLE;
            endcase
            m_lfsr = lfsr_next(m_lfsr);
            m_dprev = done_draw;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if ($time > 4) begin
            check("draw_enable", draw_enable, m_phase == P_DRAW);
            check("round_active", round_active, m_phase == P_RESP);
            check("game_over", game_over, m_phase == P_OVER);
            check("result_valid", result_valid, m_phase == P_CHECK);
            check("result_correct", result_correct, m_phase == P_CHECK && m_verdict());
            check("not_sel", not_sel, {1'b0, m_not});
            check("logic_sel", logic_sel, {1'b0, m_lg});
            check("c1_sel", c1_sel, {1'b0, m_c1});
            check("c2_sel", c2_sel, {1'b0, m_c2});
            check("score", score, m_score);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bound_fail(input string nm, input int n);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait expired after %0d cycles", nm, n);
    endtask

    task automatic wait_ph(input int ph, input int bound, input string nm);
        int n = 0;
        while (m_phase != ph && n < bound) begin tick(); n++; end
        if (m_phase != ph) bound_fail(nm, n);
    endtask

    // Start a game in the cycle whose GEN will latch an LFSR matching val/care.
    task automatic hunt_start(input bit [7:0] val, input bit [7:0] care, input string nm);
        int n = 0;
        while (!(m_phase == P_IDLE || m_phase == P_OVER) && n < 50) begin tick(); n++; end
        n = 0;
        while ((lfsr_next(m_lfsr) & 16'(care)) != 16'(val) && n < 8000) begin tick(); n++; end
        if (n >= 8000) bound_fail(nm, n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // From anywhere before WAIT_DRAW, bring the round into the response window.
    task automatic to_respond(input bit noisy);
        int d;
        wait_ph(P_WAIT, 12, "reach_wait");
        if (noisy) begin
            repeat ($urandom_range(0, 2)) begin
                key_valid = 1'b1; key_code = 2'($urandom_range(0, 3));
                start = 1'($urandom_range(0, 1));
                tick();
                key_valid = 1'b0; start = 1'b0;
            end
        end
        done_draw = 1'b1;
        if (noisy && $urandom_range(0, 3) == 0) begin
            key_valid = 1'b1; key_code = 2'($urandom_range(0, 3));
        end
        tick();
        key_valid = 1'b0;
        d = noisy ? $urandom_range(0, 3) : 0;
        done_draw = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        repeat (d) tick();
        done_draw = 1'b0;
    endtask

    function automatic int pick(input bit want);
        int off = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++)
            if (key_correct(m_not, m_lg, m_c1, m_c2, (off + i) % 4) == want) return (off + i) % 4;
        return -1;
    endfunction

    // Ends in the CHECK cycle. mode 0 correct, 1 wrong, 2 random key, 3 no key.
    task automatic answer(input int mode);
        int k;
        k = (mode == 0) ? pick(1) : (mode == 1) ? pick(0) : (mode == 2) ? $urandom_range(0, 3) : -1;
        if (k < 0) begin
            wait_ph(P_CHECK, 3 * TO, "timeout_wait");
        end else begin
            key_valid = 1'b1; key_code = 2'(k);
            tick();
            key_valid = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int mode;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // Reset state
        check("rst_draw", draw_enable, 0);
        check("rst_active", round_active, 0);
        check("rst_over", game_over, 0);
        check("rst_rv", result_valid, 0);
        check("rst_sel", {not_sel, logic_sel, c1_sel, c2_sel}, 0);
        check("rst_score", score, 0);

        // Start latency and a correct OR-free round: not=0, logic=0, c1=2
        hunt_start(8'h20, 8'h3F, "hunt_a");
        check("lat_gen_draw", draw_enable, 0);
        tick();
        check("lat_draw", draw_enable, 1);
        check("sel_bit2", {not_sel[2], logic_sel[2], c1_sel[2], c2_sel[2]}, 0);
        check("a_c1", c1_sel, 3'd2);
        check("a_logic", logic_sel, 3'd0);
        to_respond(1'b0);
        key_valid = 1'b1; key_code = 2'd2;
        tick();
        key_valid = 1'b0;
        check("a_rv", result_valid, 1);
        check("a_rc", result_correct, 1);
        tick();
        check("a_score", score, 8'd1);
        check("a_gen_draw", draw_enable, 0);
        tick();
        check("a_redraw", draw_enable, 1);
        to_respond(1'b0);
        answer(1);
        tick();

        // Wrong key on an OR round: not=1, logic=1, c1=0, c2=0
        hunt_start(8'h05, 8'hFF, "hunt_b");
        to_respond(1'b0);
        key_valid = 1'b1; key_code = 2'd3;
        tick();
        key_valid = 1'b0;
        check("b_rv", result_valid, 1);
        check("b_rc", result_correct, 0);
        tick();
        check("b_over", game_over, 1);
        repeat (5) tick();
        check("b_sel_hold", {not_sel, logic_sel, c1_sel, c2_sel}, {3'd1, 3'd1, 3'd0, 3'd0});
        check("b_score_hold", score, 8'd0);

`ifndef ROUND_TIMEOUT_EN
        // Keys during WAIT_DRAW are ignored; an unanswered window stays open
        hunt_start(8'h00, 8'h00, "hunt_c");
        wait_ph(P_WAIT, 12, "c_wait");
        repeat (3) begin
            key_valid = 1'b1; key_code = 2'd1;
            tick();
        end
        key_valid = 1'b0;
        done_draw = 1'b1;
        tick();
        done_draw = 1'b0;
        n = 0;
        repeat (30) begin
            if (result_valid) n++;
            tick();
        end
        check("c_no_result", n, 0);
        check("c_still_open", round_active, 1);
        answer(1);
        tick();
`else
        // Timeout on an unanswerable AND round with even not is a correct verdict
        hunt_start(8'h18, 8'hFF, "hunt_d");
        wait_ph(P_WAIT, 12, "d_wait");
        done_draw = 1'b1;
        tick();
        done_draw = 1'b0;
        check("d_active", round_active, 1);
        n = 0;
        while (!result_valid && n < 3 * TO) begin tick(); n++; end
        check("d_latency", n, TO);
        check("d_rc", result_correct, 1);
        tick();
`endif

        // Saturating score, then reset in the middle of a response window
        hunt_start(8'h00, 8'h00, "hunt_e");
        n = 0;
        while (m_score < 255 && n < 300) begin
            to_respond(1'b0);
            answer(0);
            tick();
            n++;
        end
        check("e_score_255", score, 8'd255);
        to_respond(1'b0);
        answer(0);
        check("e_rc", result_correct, 1);
        tick();
        check("e_score_sat", score, 8'd255);
        to_respond(1'b0);
        check("e_active", round_active, 1);
        resetn = 1'b0;
        #1;
        check("e_async_outs", {draw_enable, round_active, game_over, result_valid, result_correct}, 0);
        check("e_async_sel", {not_sel, logic_sel, c1_sel, c2_sel}, 0);
        check("e_async_score", score, 0);
        tick();
        check("e_no_rv", result_valid, 0);
        resetn = 1'b1;
        tick();

        // Randomized games
        for (int g = 0; g < 25; g++) begin
            repeat ($urandom_range(0, 5)) tick();
            hunt_start(8'h00, 8'h00, "rnd_start");
            for (int r = 0; r < 12; r++) begin
                to_respond(1'b1);
                mode = ($urandom_range(0, 99) < 80) ? 0 : $urandom_range(1, 2);
`ifdef ROUND_TIMEOUT_EN
                if ($urandom_range(0, 9) == 0) mode = 3;
`endif
                answer(mode);
                tick();
                if (m_phase == P_OVER) break;
            end
            if (m_phase != P_OVER) pulse_reset();
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
